// File: rtl/cmos_pkg.sv
// Shared types and helpers for the CMOS frame packer.
package cmos_pkg;

    localparam int PIX_W = 16;

    typedef enum logic [1:0] {
        SKIP   = 2'd0,
        WAIT   = 2'd1,
        ACTIVE = 2'd2,
        DROP   = 2'd3
    } state_t;

    function automatic int pix_per_word(input int out_width);
        return out_width / PIX_W;
    endfunction

endpackage

// File: rtl/cmos_word_packer.sv
// Lane packer: collects 16-bit pixels into OUT_WIDTH words, lane 0 in the LSBs, zero-padded flush.
// Latency: 1 cycle from the completing pixel (or flush request) to wr_en_o.
// Backpressure: a ready word seen with fifo_full_i is discarded; the lanes restart either way.
module cmos_word_packer
    import cmos_pkg::*;
#(
    parameter int OUT_WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 clr_i,
    input  logic                 pix_vld_i,
    input  logic [PIX_W-1:0]     pix_dat_i,
    input  logic                 flush_i,
    input  logic                 fifo_full_i,
    output logic                 word_rdy_o,
    output logic                 wr_en_o,
    output logic [OUT_WIDTH-1:0] wr_data_o
);

    localparam int PPW   = pix_per_word(OUT_WIDTH);
    localparam int IDX_W = $clog2(PPW);

    logic [PPW-1:0][PIX_W-1:0] lanes_q, lanes_d, lanes_fill;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      wr_en_q, wr_en_d;
    logic [OUT_WIDTH-1:0]      wr_data_q, wr_data_d;
    logic                      full_rdy, flush_rdy;

    always_comb begin
        lanes_fill = lanes_q;
        if (pix_vld_i) begin
            lanes_fill[idx_q] = pix_dat_i;
        end
        full_rdy   = pix_vld_i && (idx_q == IDX_W'(PPW - 1));
        flush_rdy  = flush_i && (idx_q != '0);
        word_rdy_o = full_rdy || flush_rdy;

        lanes_d   = lanes_q;
        idx_d     = idx_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        if (clr_i) begin
            lanes_d = '0;
            idx_d   = '0;
        end else if (word_rdy_o) begin
            // Lanes are zeroed after every word so a later flush pads its upper lanes with zeros.
            lanes_d = '0;
            idx_d   = '0;
            if (!fifo_full_i) begin
                wr_en_d   = 1'b1;
                wr_data_d = lanes_fill;
            end
        end else if (pix_vld_i) begin
            lanes_d = lanes_fill;
            idx_d   = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lanes_q   <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            lanes_q   <= lanes_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_data_o = wr_data_q;

endmodule

// File: rtl/cmos_frame_packer.sv
// Frame packer: skips settling frames, packs pixels into FIFO words, flags line/frame size errors.
// Latency: 1 cycle from a word's last pixel (or href fall for a partial word) to wr_en.
// Backpressure: fifo_full on a ready word drops it, sets ovf_sticky, drops the frame; CMOS_PACKER_STATS_EN adds stats ports.
module cmos_frame_packer
    import cmos_pkg::*;
#(
    parameter int OUT_WIDTH   = 64,
    parameter int SKIP_FRAMES = 10,
    parameter int H_ACT       = 1280,
    parameter int V_ACT       = 720
) (
    input  logic                       cmos_pclk,
    input  logic                       rst_n,
    input  logic                       cmos_href_delay,
    input  logic [PIX_W-1:0]           cmos_data_delay,
    input  logic                       vsync_pulse,
    input  logic                       fifo_full,
    output logic                       wr_en,
    output logic [OUT_WIDTH-1:0]       wr_data,
    output logic                       wr_sof,
    output logic                       frame_done,
    output logic                       line_err,
    output logic                       frame_err,
    output logic                       ovf_sticky
`ifdef CMOS_PACKER_STATS_EN
    ,
    output logic [$clog2(H_ACT+2)-1:0] last_line_pix,
    output logic [$clog2(V_ACT+2)-1:0] last_frame_lines,
    output logic [15:0]                frame_cnt
`endif
);

    localparam int PIX_CNT_W  = $clog2(H_ACT + 2);
    localparam int LINE_CNT_W = $clog2(V_ACT + 2);
    localparam int SKIP_W     = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam state_t RST_STATE = (SKIP_FRAMES > 0) ? SKIP : WAIT;

    state_t                state_q, state_d;
    logic [SKIP_W-1:0]     skip_cnt_q, skip_cnt_d;
    logic [PIX_CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic                  href_dly_q, href_dly_d;
    logic                  hold_q, hold_d;
    logic                  sof_arm_q, sof_arm_d;
    logic                  ovf_q, ovf_d;
    logic                  wr_sof_q, wr_sof_d;
    logic                  frame_done_q, frame_done_d;
    logic                  line_err_q, line_err_d;
    logic                  frame_err_q, frame_err_d;
    logic                  enter;
    logic                  href_eff, pix_vld, line_end, word_rdy;

    // A line cut by vsync is ignored until href drops, so its tail never looks like a new line.
    assign href_eff   = cmos_href_delay && !hold_q;
    assign pix_vld    = (state_q == ACTIVE) && href_eff && !vsync_pulse;
    assign line_end   = (state_q == ACTIVE) && href_dly_q && !href_eff && !vsync_pulse;
    assign hold_d     = cmos_href_delay && (vsync_pulse || hold_q);
    assign href_dly_d = href_eff && !vsync_pulse;

    always_comb begin
        state_d      = state_q;
        skip_cnt_d   = skip_cnt_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        sof_arm_d    = sof_arm_q;
        ovf_d        = ovf_q;
        wr_sof_d     = 1'b0;
        frame_done_d = 1'b0;
        line_err_d   = 1'b0;
        frame_err_d  = 1'b0;
        enter        = 1'b0;
        case (state_q)
            SKIP: begin
                // skip_cnt counts settling frames already started; the pulse after the last one captures.
                if (vsync_pulse) begin
                    if (skip_cnt_q == SKIP_W'(SKIP_FRAMES)) begin
                        enter = 1'b1;
                    end else begin
                        skip_cnt_d = skip_cnt_q + 1'b1;
                    end
                end
            end
            WAIT, DROP: begin
                if (vsync_pulse) begin
                    enter = 1'b1;
                end
            end
            ACTIVE: begin
                if (vsync_pulse) begin
                    frame_done_d = 1'b1;
                    frame_err_d  = (line_cnt_q != LINE_CNT_W'(V_ACT));
                    enter        = 1'b1;
                end else begin
                    if (pix_vld && (pix_cnt_q != '1)) begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                    if (line_end) begin
                        if (line_cnt_q != '1) begin
                            line_cnt_d = line_cnt_q + 1'b1;
                        end
                        line_err_d = (pix_cnt_q != PIX_CNT_W'(H_ACT));
                        pix_cnt_d  = '0;
                    end
                    if (word_rdy) begin
                        if (fifo_full) begin
                            ovf_d   = 1'b1;
                            state_d = DROP;
                        end else begin
                            wr_sof_d  = sof_arm_q;
                            sof_arm_d = 1'b0;
                        end
                    end
                end
            end
            default: state_d = RST_STATE;
        endcase
        if (enter) begin
            state_d    = ACTIVE;
            pix_cnt_d  = '0;
            line_cnt_d = '0;
            sof_arm_d  = 1'b1;
        end
    end

    always_ff @(posedge cmos_pclk) begin
        if (!rst_n) begin
            state_q      <= RST_STATE;
            skip_cnt_q   <= '0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            href_dly_q   <= 1'b0;
            hold_q       <= 1'b0;
            sof_arm_q    <= 1'b0;
            ovf_q        <= 1'b0;
            wr_sof_q     <= 1'b0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            skip_cnt_q   <= skip_cnt_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            href_dly_q   <= href_dly_d;
            hold_q       <= hold_d;
            sof_arm_q    <= sof_arm_d;
            ovf_q        <= ovf_d;
            wr_sof_q     <= wr_sof_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    cmos_word_packer #(
        .OUT_WIDTH (OUT_WIDTH)
    ) u_packer (
        .clk_i       (cmos_pclk),
        .rst_n_i     (rst_n),
        .clr_i       (vsync_pulse),
        .pix_vld_i   (pix_vld),
        .pix_dat_i   (cmos_data_delay),
        .flush_i     (line_end),
        .fifo_full_i (fifo_full),
        .word_rdy_o  (word_rdy),
        .wr_en_o     (wr_en),
        .wr_data_o   (wr_data)
    );

    assign wr_sof     = wr_sof_q;
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;
    assign frame_err  = frame_err_q;
    assign ovf_sticky = ovf_q;

`ifdef CMOS_PACKER_STATS_EN
    logic [PIX_CNT_W-1:0]  last_line_pix_q;
    logic [LINE_CNT_W-1:0] last_frame_lines_q;
    logic [15:0]           frame_cnt_q;
    logic                  frame_end;

    assign frame_end = (state_q == ACTIVE) && vsync_pulse;

    always_ff @(posedge cmos_pclk) begin
        if (!rst_n) begin
            last_line_pix_q    <= '0;
            last_frame_lines_q <= '0;
            frame_cnt_q        <= '0;
        end else begin
            if (line_end) begin
                last_line_pix_q <= pix_cnt_q;
            end
            if (frame_end) begin
                last_frame_lines_q <= line_cnt_q;
                frame_cnt_q        <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign last_line_pix    = last_line_pix_q;
    assign last_frame_lines = last_frame_lines_q;
    assign frame_cnt        = frame_cnt_q;
`endif

endmodule

// File: tb/tb_cmos_frame_packer.sv
// Directed + randomized bench for cmos_frame_packer, checked against a line-level reference model.
module tb_cmos_frame_packer;

    localparam int OW  = 64;
    localparam int HA  = 8;
    localparam int VA  = 2;
    localparam int PPW = OW / 16;

    logic          clk = 1'b0;
    logic          rst_n, href, vsync, full;
    logic [15:0]   data;
    logic          wr_en, wr_sof, frame_done, line_err, frame_err, ovf_sticky;
    logic [OW-1:0] wr_data;
    logic          z_wr_en, z_wr_sof, z_frame_done, z_line_err, z_frame_err, z_ovf_sticky;
    logic [OW-1:0] z_wr_data;

    always #5 clk = ~clk;

    cmos_frame_packer #(.OUT_WIDTH(OW), .SKIP_FRAMES(1), .H_ACT(HA), .V_ACT(VA)) dut (
        .cmos_pclk(clk), .rst_n(rst_n), .cmos_href_delay(href), .cmos_data_delay(data),
        .vsync_pulse(vsync), .fifo_full(full), .wr_en(wr_en), .wr_data(wr_data),
        .wr_sof(wr_sof), .frame_done(frame_done), .line_err(line_err),
        .frame_err(frame_err), .ovf_sticky(ovf_sticky));

    cmos_frame_packer #(.OUT_WIDTH(OW), .SKIP_FRAMES(0), .H_ACT(HA), .V_ACT(VA)) dut0 (
        .cmos_pclk(clk), .rst_n(rst_n), .cmos_href_delay(href), .cmos_data_delay(data),
        .vsync_pulse(vsync), .fifo_full(full), .wr_en(z_wr_en), .wr_data(z_wr_data),
        .wr_sof(z_wr_sof), .frame_done(z_frame_done), .line_err(z_line_err),
        .frame_err(z_frame_err), .ovf_sticky(z_ovf_sticky));

    typedef struct {
        int          cyc;
        logic [63:0] dat;
        logic        sof;
    } wr_t;

    wr_t         exp_wr[$], obs_wr[$], obs0_wr[$];
    int          exp_ev[$], obs_ev[$];   // cyc*4 + kind: 0 line_err, 1 frame_done, 2 frame_err
    logic [15:0] pix [0:15];
    int          cyc, n_chk, n_fail;
    bit          rec0;

    // Reference model state, tracked per line/frame.
    int          m_skip, m_lines;
    bit          m_cap, m_drop, m_sof;
    logic        m_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic h, input logic [15:0] d, input logic v, input logic f);
        wr_t e;
        href = h; data = d; vsync = v; full = f;
        @(posedge clk);
        #1;
        if (wr_en) begin
            e.cyc = cyc; e.dat = wr_data; e.sof = wr_sof;
            obs_wr.push_back(e);
        end
        if (rec0 && z_wr_en) begin
            e.cyc = cyc; e.dat = z_wr_data; e.sof = z_wr_sof;
            obs0_wr.push_back(e);
        end
        if (line_err)   obs_ev.push_back(cyc * 4 + 0);
        if (frame_done) obs_ev.push_back(cyc * 4 + 1);
        if (frame_err)  obs_ev.push_back(cyc * 4 + 2);
        cyc++;
    endtask

    function automatic logic [63:0] pack(input int w, input int n);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < PPW; k++)
            if (w * PPW + k < n) r[16*k +: 16] = pix[w * PPW + k];
        return r;
    endfunction

    task automatic model_reset();
        m_skip = 1; m_cap = 0; m_drop = 0; m_sof = 0; m_lines = 0; m_ovf = 1'b0;
    endtask

    task automatic push_wr(input int c, input logic [63:0] d);
        wr_t e;
        e.cyc = c; e.dat = d; e.sof = m_sof;
        exp_wr.push_back(e);
        m_sof = 0;
    endtask

    task automatic model_vsync(input int c);
        if (m_cap && !m_drop) begin
            exp_ev.push_back(c * 4 + 1);
            if (m_lines != VA) exp_ev.push_back(c * 4 + 2);
        end
        if (m_skip > 0) m_skip--;
        else begin
            m_cap = 1; m_drop = 0; m_sof = 1; m_lines = 0;
        end
    endtask

    task automatic do_vsync();
        model_vsync(cyc);
        tick(0, 16'h0, 1, 0);
        tick(0, 16'h0, 0, 0);
    endtask

    // n pixels; fifo_full on pixel full_at; vsync on pixel vs_at (-1 = none).
    task automatic do_line(input int n, input int full_at, input int vs_at, input bit rnd, input logic [15:0] base);
        bit f;
        bit cut;
        cut = 0;
        for (int i = 0; i < n; i++) pix[i] = rnd ? 16'($urandom) : base + 16'(i);
        for (int i = 0; i < n; i++) begin
            if (i == vs_at) begin
                model_vsync(cyc);
                tick(1, pix[i], 1, 0);
                cut = 1;
                break;
            end
            f = (i == full_at);
            if (m_cap && !m_drop && (i % PPW == PPW - 1)) begin
                if (f) begin
                    m_drop = 1; m_ovf = 1'b1;
                end else push_wr(cyc, pack(i / PPW, n));
            end
            tick(1, pix[i], 0, f);
        end
        if (!cut && m_cap && !m_drop) begin
            if (n % PPW != 0) push_wr(cyc, pack(n / PPW, n));
            if (n != HA) exp_ev.push_back(cyc * 4 + 0);
            m_lines++;
        end
        tick(0, 16'h0, 0, 0);
        tick(0, 16'h0, 0, 0);
    endtask

    task automatic check_all(input string tag);
        int n;
        chk({tag, "_wr_count"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
        n = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_wr_cycle"}, 64'(obs_wr[i].cyc), 64'(exp_wr[i].cyc));
            chk({tag, "_wr_data"}, obs_wr[i].dat, exp_wr[i].dat);
            chk({tag, "_wr_sof"}, 64'(obs_wr[i].sof), 64'(exp_wr[i].sof));
        end
        chk({tag, "_event_count"}, 64'(obs_ev.size()), 64'(exp_ev.size()));
        n = (obs_ev.size() < exp_ev.size()) ? obs_ev.size() : exp_ev.size();
        for (int i = 0; i < n; i++) chk({tag, "_event"}, 64'(obs_ev[i]), 64'(exp_ev[i]));
        chk({tag, "_ovf_sticky"}, 64'(ovf_sticky), 64'(m_ovf));
        exp_wr.delete(); obs_wr.delete(); exp_ev.delete(); obs_ev.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, 64'(wr_en), 64'(0));
        chk({tag, "_wr_data"}, wr_data, 64'(0));
        chk({tag, "_wr_sof"}, 64'(wr_sof), 64'(0));
        chk({tag, "_frame_done"}, 64'(frame_done), 64'(0));
        chk({tag, "_line_err"}, 64'(line_err), 64'(0));
        chk({tag, "_frame_err"}, 64'(frame_err), 64'(0));
        chk({tag, "_ovf_sticky"}, 64'(ovf_sticky), 64'(0));
        chk({tag, "_skip0_wr_en"}, 64'(z_wr_en), 64'(0));
        chk({tag, "_skip0_wr_data"}, z_wr_data, 64'(0));
        chk({tag, "_skip0_ovf"}, 64'(z_ovf_sticky), 64'(0));
        chk({tag, "_skip0_frame_done"}, 64'(z_frame_done), 64'(0));
    endtask

    initial begin
        int lc, vc, nl, n, fa;
        logic [63:0] w0, w1;
        n_chk = 0; n_fail = 0; cyc = 0; rec0 = 0;
        rst_n = 0; href = 0; vsync = 0; full = 0; data = '0;
        model_reset();
        tick(0, 16'h0, 0, 0);
        tick(0, 16'h0, 0, 0);
        chk_reset_outputs("reset");
        rst_n = 1;

        // Skip one settling frame, then capture one 2x8 frame.
        do_vsync();
        do_line(8, -1, -1, 0, 16'h0001);
        do_line(8, -1, -1, 0, 16'h0009);
        do_vsync();
        do_line(8, -1, -1, 0, 16'h0001);
        do_line(8, -1, -1, 0, 16'h0009);
        do_vsync();
        if (obs_wr.size() > 0) begin
            chk("skip_first_word", obs_wr[0].dat, 64'h0004_0003_0002_0001);
            chk("skip_first_sof", 64'(obs_wr[0].sof), 64'(1));
        end
        check_all("skip_capture");

        // Short line with zero-padded flush one cycle after href falls.
        lc = cyc + 6;
        do_line(6, -1, -1, 0, 16'h000A);
        if (obs_wr.size() > 1) begin
            chk("partial_word", obs_wr[1].dat, 64'h0000_0000_000F_000E);
            chk("partial_cycle", 64'(obs_wr[1].cyc), 64'(lc));
        end
        do_line(8, -1, -1, 1, 16'h0);
        do_vsync();
        check_all("partial");

        // FIFO full on the second word: frame dropped until the next vsync.
        do_line(8, 7, -1, 1, 16'h0);
        chk("ovf_set", 64'(ovf_sticky), 64'(1));
        do_line(8, -1, -1, 1, 16'h0);
        do_vsync();
        do_line(8, -1, -1, 1, 16'h0);
        do_line(8, -1, -1, 1, 16'h0);
        do_vsync();
        check_all("overflow");

        // Single-line frame.
        do_line(8, -1, -1, 1, 16'h0);
        vc = cyc;
        do_vsync();
        if (obs_ev.size() >= 2) begin
            chk("short_frame_done", 64'(obs_ev[obs_ev.size()-2]), 64'(vc * 4 + 1));
            chk("short_frame_err", 64'(obs_ev[obs_ev.size()-1]), 64'(vc * 4 + 2));
        end
        check_all("short_frame");

        // vsync on the 3rd pixel of a line.
        do_line(5, -1, 2, 1, 16'h0);
        do_line(8, -1, -1, 1, 16'h0);
        do_line(8, -1, -1, 1, 16'h0);
        do_vsync();
        check_all("vsync_mid_line");

        // Random frames, occasional FIFO-full.
        for (int f = 0; f < 8; f++) begin
            nl = $urandom_range(1, 3);
            for (int l = 0; l < nl; l++) begin
                n  = $urandom_range(3, 10);
                fa = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
                do_line(n, fa, -1, 1, 16'h0);
            end
            do_vsync();
            check_all("random");
        end

        // Reset after 3 pixels of a line.
        do_vsync();
        tick(1, 16'h1111, 0, 0);
        tick(1, 16'h2222, 0, 0);
        tick(1, 16'h3333, 0, 0);
        check_all("pre_reset");
        rst_n = 0;
        tick(0, 16'h0, 0, 0);
        chk_reset_outputs("mid_reset");
        rst_n = 1;
        model_reset();
        obs0_wr.delete();
        rec0 = 1;
        do_vsync();
        do_line(8, -1, -1, 0, 16'h0100);
        w0 = pack(0, 8);
        w1 = pack(1, 8);
        chk("skip0_wr_count", 64'(obs0_wr.size()), 64'(2));
        if (obs0_wr.size() >= 2) begin
            chk("skip0_word0", obs0_wr[0].dat, w0);
            chk("skip0_sof0", 64'(obs0_wr[0].sof), 64'(1));
            chk("skip0_word1", obs0_wr[1].dat, w1);
            chk("skip0_sof1", 64'(obs0_wr[1].sof), 64'(0));
        end
        do_vsync();
        do_line(8, -1, -1, 1, 16'h0);
        do_line(8, -1, -1, 1, 16'h0);
        do_vsync();
        check_all("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
